// File: rtl/btn_debounce_pulse_pkg.sv
// Shared definitions for the push-button debouncer.
//   btn_state_t             : 2-bit debounce FSM state encoding
//   DEFAULT_DEBOUNCE_CYCLES : stable-sample count for the 100 MHz board clock (10 ms)
//   DEFAULT_HOLD_CYCLES     : long-hold delay for the 100 MHz board clock (1 s)
package btn_debounce_pulse_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } btn_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEFAULT_HOLD_CYCLES     = 100_000_000;

endpackage

// File: rtl/btn_debounce_pulse_if.sv
// Button signal bundle between the board-side pin driver and the debouncer.
//   btn_raw     : raw, bouncy, active-high button pin
//   btn_level   : debounced button level
//   btn_press   : one-cycle pulse on debounced 0->1
//   btn_release : one-cycle pulse on debounced 1->0
//   btn_hold    : one-cycle pulse after a long continuous press
// master = side that owns the pin and consumes the events; slave = the debouncer.
interface btn_debounce_pulse_if;

  logic btn_raw;
  logic btn_level;
  logic btn_press;
  logic btn_release;
  logic btn_hold;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_hold
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_hold
  );

endinterface

// File: rtl/btn_debounce_pulse_sync_2ff.sv
// Generic two-flop synchronizer for asynchronous input pins.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both stages
//   d     : asynchronous input
//   q     : synchronized output (second stage)
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: synchronizes the raw pin, debounces it into a clean
// level and emits single-cycle press, release and long-hold pulses. btn_press
// feeds the downstream start/stop toggle FSM.
//   clk   : system clock, all logic on posedge
//   rst_n : asynchronous active-low reset
//   btn   : slave side of btn_debounce_pulse_if (btn_raw in; level and pulses out)
module btn_debounce_pulse
  import btn_debounce_pulse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  btn_debounce_pulse_if.slave  btn
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);

  // With a single-sample debounce the change is accepted on the edge that
  // first sees it, so the pending states are never entered.
  localparam bit SKIP_PEND = (DEBOUNCE_CYCLES == 1);

  logic              btn_s;
  btn_state_t        state;
  logic [DEB_W-1:0]  deb_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              level_q;
  logic              press_q;
  logic              release_q;
  logic              hold_q;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn.btn_raw),
    .q     (btn_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RELEASED;
      deb_cnt   <= '0;
      hold_cnt  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      hold_q    <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      hold_q    <= 1'b0;

      // Hold timer runs whenever the debounced level is high (PRESSED and
      // RELEASE_PEND) and parks at HOLD_MAX so only one hold pulse per press.
      if (level_q && (hold_cnt != HOLD_MAX)) begin
        hold_cnt <= hold_cnt + HOLD_ONE;
        if (hold_cnt == HOLD_LAST) begin
          hold_q <= 1'b1;
        end
      end

      case (state)
        RELEASED: begin
          if (btn_s) begin
            if (SKIP_PEND) begin
              state    <= PRESSED;
              level_q  <= 1'b1;
              press_q  <= 1'b1;
              hold_cnt <= '0;
            end else begin
              state   <= PRESS_PEND;
              deb_cnt <= DEB_ONE;
            end
          end
        end

        PRESS_PEND: begin
          if (!btn_s) begin
            state   <= RELEASED;
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state    <= PRESSED;
            level_q  <= 1'b1;
            press_q  <= 1'b1;
            hold_cnt <= '0;
          end else begin
            deb_cnt <= deb_cnt + DEB_ONE;
          end
        end

        PRESSED: begin
          if (!btn_s) begin
            if (SKIP_PEND) begin
              state     <= RELEASED;
              level_q   <= 1'b0;
              release_q <= 1'b1;
              hold_cnt  <= '0;
            end else begin
              state   <= RELEASE_PEND;
              deb_cnt <= DEB_ONE;
            end
          end
        end

        RELEASE_PEND: begin
          if (btn_s) begin
            state   <= PRESSED;
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state     <= RELEASED;
            level_q   <= 1'b0;
            release_q <= 1'b1;
            hold_cnt  <= '0;
          end else begin
            deb_cnt <= deb_cnt + DEB_ONE;
          end
        end

        default: begin
          state <= RELEASED;
        end
      endcase
    end
  end

  assign btn.btn_level   = level_q;
  assign btn.btn_press   = press_q;
  assign btn.btn_release = release_q;
  assign btn.btn_hold    = hold_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Self-checking bench for btn_debounce_pulse with DEBOUNCE_CYCLES=4, HOLD_CYCLES=20.
// Expected pulse events are queued when a stimulus pattern is driven and popped
// as the DUT emits pulses; btn_level is compared every cycle.
module tb_btn_debounce_pulse;
  import btn_debounce_pulse_pkg::*;

  localparam int DEB  = 4;
  localparam int HOLD = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic count_en;

  btn_debounce_pulse_if bif ();

  btn_debounce_pulse #(
    .DEBOUNCE_CYCLES (DEB),
    .HOLD_CYCLES     (HOLD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bif)
  );

  always #5 clk = ~clk;

  // Downstream start/stop toggle FSM driven by btn_press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_en <= 1'b0;
    end else if (bif.btn_press) begin
      count_en <= ~count_en;
    end
  end

  typedef enum int {EV_PRESS, EV_RELEASE, EV_HOLD} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       cyc;
  } ev_t;

  // Pattern char r = btn_raw for the r-th driven cycle; press_at/release_at are
  // the relative cycle numbers where the pulse appears (-1 = never).
  typedef struct {
    string name;
    string pat;
    int    press_at;
    int    release_at;
  } vec_t;

  ev_t  sb[$];
  vec_t vecs[8];
  int   cyc    = 0;
  int   nCheck = 0;
  int   nPass  = 0;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCheck++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic stepCycle(input logic raw);
    bif.btn_raw = raw;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic expectEvent(input ev_kind_t k, input int c);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic checkPulse(input string name, input ev_kind_t k, input logic p);
    ev_t e;
    if (p === 1'b1) begin
      if (sb.size() == 0) begin
        nCheck++;
        $display("[TB] FAIL %s unexpected %s: got pulse at cycle %0d, expected none", name, k.name(), cyc);
      end else begin
        e = sb.pop_front();
        checkVal({name, " ", k.name(), " kind"}, k, e.kind);
        checkVal({name, " ", k.name(), " cycle"}, cyc, e.cyc);
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic exp_level);
    checkVal({name, " level"}, bif.btn_level, exp_level);
    checkPulse(name, EV_PRESS, bif.btn_press);
    checkPulse(name, EV_RELEASE, bif.btn_release);
    checkPulse(name, EV_HOLD, bif.btn_hold);
  endtask

  task automatic drainCheck(input string name);
    checkVal({name, " missing events"}, sb.size(), 0);
    sb.delete();
    checkVal({name, " fsm state"}, dut.state, RELEASED);
  endtask

  task automatic applyStimulus(input vec_t v);
    int   base;
    logic lvl;
    base = cyc;
    if (v.press_at >= 0) expectEvent(EV_PRESS, base + 1 + v.press_at);
    if (v.release_at >= 0) expectEvent(EV_RELEASE, base + 1 + v.release_at);
    for (int r = 0; r < v.pat.len(); r++) begin
      stepCycle(v.pat[r] == "1");
      lvl = (v.press_at >= 0) && (r >= v.press_at) && ((v.release_at < 0) || (r < v.release_at));
      checkOutput(v.name, lvl);
    end
    drainCheck(v.name);
  endtask

  initial begin
    int base;
    int exp_en[3];

    vecs[0] = '{"clean",        "11111111110000000000",          5, 15};
    vecs[1] = '{"press_bounce", "1110110000000000",             -1, -1};
    vecs[2] = '{"glitch",       "10000000",                     -1, -1};
    vecs[3] = '{"rel_bounce",   "11111111110010000000000000",    5, 18};
    vecs[4] = '{"late_accept",  "101111111111000000000000",      7, 17};
    vecs[5] = '{"exact_deb",    "1111000000000000",              5,  9};
    vecs[6] = '{"short_deb",    "111000000000",                 -1, -1};
    vecs[7] = '{"bouncy",       "10110111111111101000000000000", 10, 22};
    exp_en  = '{1, 0, 1};

    bif.btn_raw = 1'b0;
    rst_n       = 1'b0;
    repeat (2) begin
      stepCycle(1'b0);
      checkOutput("reset", 1'b0);
    end
    checkVal("reset count_en", count_en, 1'b0);
    #2 rst_n = 1'b1;

    $display("[TB] table vectors");
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    $display("[TB] long hold");
    base = cyc;
    expectEvent(EV_PRESS, base + 6);
    expectEvent(EV_HOLD, base + 26);
    expectEvent(EV_RELEASE, base + 66);
    for (int r = 0; r < 72; r++) begin
      stepCycle(r < 60);
      checkOutput("long_hold", (r >= 5) && (r < 65));
    end
    drainCheck("long_hold");

    $display("[TB] hold across release bounce");
    base = cyc;
    expectEvent(EV_PRESS, base + 6);
    expectEvent(EV_HOLD, base + 26);
    expectEvent(EV_RELEASE, base + 46);
    for (int r = 0; r < 52; r++) begin
      stepCycle((r < 40) && (r != 20) && (r != 21));
      checkOutput("hold_glitch", (r >= 5) && (r < 45));
    end
    drainCheck("hold_glitch");

    $display("[TB] reset mid-press");
    base = cyc;
    expectEvent(EV_PRESS, base + 6);
    for (int r = 0; r < 10; r++) begin
      stepCycle(1'b1);
      checkOutput("pre_reset", r >= 5);
    end
    #2 rst_n = 1'b0;
    #1;
    checkVal("async reset level", bif.btn_level, 1'b0);
    checkVal("async reset pulses", {bif.btn_press, bif.btn_release, bif.btn_hold}, 3'b000);
    for (int r = 0; r < 2; r++) begin
      stepCycle(1'b1);
      checkOutput("in_reset", 1'b0);
    end
    #2 rst_n = 1'b1;
    base = cyc;
    expectEvent(EV_PRESS, base + 6);
    expectEvent(EV_RELEASE, base + 18);
    for (int r = 0; r < 24; r++) begin
      stepCycle(r < 12);
      checkOutput("post_reset", (r >= 5) && (r < 17));
    end
    drainCheck("post_reset");

    $display("[TB] toggle integration");
    #2 rst_n = 1'b0;
    stepCycle(1'b0);
    checkVal("toggle reset count_en", count_en, 1'b0);
    #2 rst_n = 1'b1;
    for (int p = 0; p < 3; p++) begin
      applyStimulus(vecs[7]);
      checkVal("toggle count_en", count_en, exp_en[p]);
    end

    $display("%0d/%0d checks passed", nPass, nCheck);
    $finish;
  end

endmodule
